// File: rtl/alu_issue_unit_if.sv
// rtl/alu_issue_unit_if.sv - instruction accept and retire handshake bundle
interface alu_issue_unit_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        done_valid;
    logic        done_ready;
    logic [31:0] done_result;
    logic [2:0]  done_flags;
    logic        done_branch_taken;
    logic        done_exc;
    logic        done_illegal;

    modport master (
        output instr_valid, instr, done_ready,
        input  instr_ready, done_valid, done_result, done_flags,
               done_branch_taken, done_exc, done_illegal
    );

    modport slave (
        input  instr_valid, instr, done_ready,
        output instr_ready, done_valid, done_result, done_flags,
               done_branch_taken, done_exc, done_illegal
    );
endinterface

// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - issues one instruction to a combinational alu and retires it
module alu_issue_unit #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_unit_if.slave  bus,
    output logic [XLEN-1:0]  alu_instruction,
    output logic [XLEN-1:0]  alu_regA,
    output logic [XLEN-1:0]  alu_regB,
    input  logic [XLEN-1:0]  alu_result,
    input  logic [2:0]       alu_flags,
    input  logic             init_we,
    input  logic [4:0]       init_addr,
    input  logic [XLEN-1:0]  init_data,
    input  logic [4:0]       dbg_addr,
    output logic [XLEN-1:0]  dbg_data
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXEC   = 2'd1;
    localparam logic [1:0] S_RETIRE = 2'd2;

    logic [1:0]      state;
    logic [XLEN-1:0] rf [NREGS];

    // decoded class of the instruction in flight
    logic       pend_we, pend_ovf, pend_illegal, pend_beq, pend_bne;
    logic [4:0] pend_dest;

    logic       dec_we, dec_ovf, dec_illegal, dec_beq, dec_bne;
    logic [4:0] dec_dest;
    logic [4:0] rs, rt;
    logic [XLEN-1:0] op_a, op_b;
    logic       accept, init_en, wb_en;

    assign rs      = bus.instr[25:21];
    assign rt      = bus.instr[20:16];
    assign accept  = (state == S_IDLE) && bus.instr_valid;
    assign init_en = (state == S_IDLE) && init_we && (init_addr != 5'd0);
    // overflow on a trapping add/sub suppresses the write; $0 is never written
    assign wb_en   = (state == S_EXEC) && pend_we && (pend_dest != 5'd0)
                     && !(pend_ovf && alu_flags[0]);

    assign bus.instr_ready = (state == S_IDLE);
    assign bus.done_valid  = (state == S_RETIRE);
    assign dbg_data        = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];

    // operand read; a same-cycle preload write is forwarded so the accept sees it
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (rs != 5'd0) op_a = (init_en && init_addr == rs) ? init_data : rf[rs];
        if (rt != 5'd0) op_b = (init_en && init_addr == rt) ? init_data : rf[rt];
    end

    // decode the writeback destination and instruction class
    always_comb begin
        dec_we      = 1'b0;
        dec_ovf     = 1'b0;
        dec_illegal = 1'b0;
        dec_beq     = 1'b0;
        dec_bne     = 1'b0;
        dec_dest    = rt;
        case (bus.instr[31:26])
            6'h00: begin
                dec_dest = bus.instr[15:11];
                case (bus.instr[5:0])
                    6'h20, 6'h22: begin dec_we = 1'b1; dec_ovf = 1'b1; end
                    6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: dec_we = 1'b1;
                    default: dec_illegal = 1'b1;
                endcase
            end
            6'h08: begin dec_we = 1'b1; dec_ovf = 1'b1; end
            6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: dec_we = 1'b1;
            6'h04: dec_beq = 1'b1;
            6'h05: dec_bne = 1'b1;
            6'h23, 6'h2b: ;
            default: dec_illegal = 1'b1;
        endcase
    end

    // control FSM, alu drive registers and retire record
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= S_IDLE;
            alu_instruction       <= '0;
            alu_regA              <= '0;
            alu_regB              <= '0;
            pend_we               <= 1'b0;
            pend_ovf              <= 1'b0;
            pend_illegal          <= 1'b0;
            pend_beq              <= 1'b0;
            pend_bne              <= 1'b0;
            pend_dest             <= '0;
            bus.done_result       <= '0;
            bus.done_flags        <= '0;
            bus.done_branch_taken <= 1'b0;
            bus.done_exc          <= 1'b0;
            bus.done_illegal      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    alu_instruction <= bus.instr;
                    alu_regA        <= op_a;
                    alu_regB        <= op_b;
                    pend_we         <= dec_we;
                    pend_ovf        <= dec_ovf;
                    pend_illegal    <= dec_illegal;
                    pend_beq        <= dec_beq;
                    pend_bne        <= dec_bne;
                    pend_dest       <= dec_dest;
                    state           <= S_EXEC;
                end
                S_EXEC: begin
                    bus.done_result       <= alu_result;
                    bus.done_flags        <= alu_flags;
                    bus.done_branch_taken <= (pend_beq && alu_flags[2]) || (pend_bne && !alu_flags[2]);
                    bus.done_exc          <= pend_ovf && alu_flags[0];
                    bus.done_illegal      <= pend_illegal;
                    state                 <= S_RETIRE;
                end
                S_RETIRE: if (bus.done_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // register file: preload in IDLE, writeback at the end of EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (init_en) begin
            rf[init_addr] <= init_data;
        end else if (wb_en) begin
            rf[pend_dest] <= alu_result;
        end
    end
endmodule

// File: tb/tb_alu_issue_unit.sv
// tb/tb_alu_issue_unit.sv - scoreboard bench for alu_issue_unit with a behavioural alu
module tb_alu_issue_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] alu_instruction, alu_regA, alu_regB, alu_result;
    logic [2:0]  alu_flags;
    logic        init_we = 1'b0;
    logic [4:0]  init_addr = '0;
    logic [31:0] init_data = '0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    alu_issue_unit_if bus ();

    alu_issue_unit dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_instruction(alu_instruction), .alu_regA(alu_regA), .alu_regB(alu_regB),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [2:0]  flags;
        logic        taken, exc, illegal, we;
        logic [4:0]  dest;
    } exp_t;

    exp_t        sb [$];
    exp_t        last;
    logic [31:0] m [32];
    int          vectors = 0;
    int          miscompares = 0;

    // behavioural alu: returns {flags, result}
    function automatic logic [34:0] alu_model(logic [31:0] ins, logic [31:0] a, logic [31:0] b);
        logic [31:0] r, imm;
        logic        ovf;
        r = '0; ovf = 1'b0;
        imm = {{16{ins[15]}}, ins[15:0]};
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20, 6'h21: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
                6'h22, 6'h23: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = ~(a | b);
                6'h2a: r = {31'd0, $signed(a) < $signed(b)};
                6'h2b: r = {31'd0, a < b};
                6'h00: r = b << ins[10:6];
                6'h02: r = b >> ins[10:6];
                6'h03: r = $signed(b) >>> ins[10:6];
                6'h04: r = b << a[4:0];
                6'h06: r = b >> a[4:0];
                6'h07: r = $signed(b) >>> a[4:0];
                default: r = '0;
            endcase
            6'h08, 6'h09: begin r = a + imm; ovf = (a[31] == imm[31]) && (r[31] != a[31]); end
            6'h0a: r = {31'd0, $signed(a) < $signed(imm)};
            6'h0b: r = {31'd0, a < imm};
            6'h0c: r = a & {16'd0, ins[15:0]};
            6'h0d: r = a | {16'd0, ins[15:0]};
            6'h0e: r = a ^ {16'd0, ins[15:0]};
            6'h04, 6'h05: r = a - b;
            6'h23, 6'h2b: r = a + imm;
            default: r = '0;
        endcase
        return {r == 32'd0, r[31], ovf, r};
    endfunction

    assign {alu_flags, alu_result} = alu_model(alu_instruction, alu_regA, alu_regB);

    function automatic logic [31:0] rdm(logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : m[a];
    endfunction

    function automatic exp_t predict(logic [31:0] ins);
        exp_t        e;
        logic [34:0] o;
        logic        trap, known;
        logic [5:0]  op, fn;
        op = ins[31:26]; fn = ins[5:0];
        o = alu_model(ins, rdm(ins[25:21]), rdm(ins[20:16]));
        e.result = o[31:0];
        e.flags  = o[34:32];
        trap  = (op == 6'h08) || (op == 6'h00 && (fn == 6'h20 || fn == 6'h22));
        known = (op == 6'h00) ? (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                            6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07})
                              : (op inside {6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e,
                                            6'h04, 6'h05, 6'h23, 6'h2b});
        e.illegal = !known;
        e.exc     = trap && e.flags[0];
        e.taken   = (op == 6'h04 && e.flags[2]) || (op == 6'h05 && !e.flags[2]);
        e.dest    = (op == 6'h00) ? ins[15:11] : ins[20:16];
        e.we      = known && !e.exc && !(op inside {6'h04, 6'h05, 6'h23, 6'h2b});
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    task automatic chk_reg(input logic [4:0] a, input logic [31:0] want);
        dbg_addr = a;
        #1;
        chk($sformatf("dbg_R%0d", a), dbg_data, want);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.instr_ready && n < 12) begin @(negedge clk); n++; end
        chk("idle_timeout", {31'd0, bus.instr_ready}, 32'd1);
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wait_idle();
        init_we = 1'b1; init_addr = a; init_data = d;
        @(negedge clk);
        init_we = 1'b0;
        if (a != 5'd0) m[a] = d;
    endtask

    // present ins at a negedge in IDLE, return at the negedge after the accept edge
    task automatic send(input logic [31:0] ins);
        wait_idle();
        bus.instr_valid = 1'b1;
        bus.instr = ins;
        sb.push_back(predict(ins));
        @(negedge clk);
        bus.instr_valid = 1'b0;
        chk("alu_instruction", alu_instruction, ins);
        chk("alu_regA", alu_regA, rdm(ins[25:21]));
        chk("alu_regB", alu_regB, rdm(ins[20:16]));
    endtask

    task automatic wait_done();
        int n = 2;
        @(negedge clk);
        while (!bus.done_valid && n < 14) begin @(negedge clk); n++; end
        chk("latency", n, 2);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        last = sb.pop_front();
        chk("done_result", bus.done_result, last.result);
        chk("done_flags", {29'd0, bus.done_flags}, {29'd0, last.flags});
        chk("done_branch_taken", {31'd0, bus.done_branch_taken}, {31'd0, last.taken});
        chk("done_exc", {31'd0, bus.done_exc}, {31'd0, last.exc});
        chk("done_illegal", {31'd0, bus.done_illegal}, {31'd0, last.illegal});
        if (last.we && last.dest != 5'd0) m[last.dest] = last.result;
    endtask

    task automatic release_done();
        bus.done_ready = 1'b1;
        @(negedge clk);
        bus.done_ready = 1'b0;
        chk("ready_after_retire", {31'd0, bus.instr_ready}, 32'd1);
        chk("done_valid_cleared", {31'd0, bus.done_valid}, 32'd0);
    endtask

    task automatic run(input logic [31:0] ins);
        send(ins);
        wait_done();
        release_done();
        if (last.we) chk_reg(last.dest, rdm(last.dest));
    endtask

    logic [5:0] rfun [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    logic [5:0] iops [7]  = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e};

    initial begin
        logic [31:0] held_result, ins;
        for (int i = 0; i < 32; i++) m[i] = '0;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        bus.done_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset_instr_ready", {31'd0, bus.instr_ready}, 32'd1);
        chk("reset_done_valid", {31'd0, bus.done_valid}, 32'd0);
        chk("reset_alu_instruction", alu_instruction, 32'd0);
        chk("reset_done_result", bus.done_result, 32'd0);
        chk_reg(5'd5, 32'd0);

        // add $3,$1,$2 with 1+1
        preload(5'd1, 32'd1);
        preload(5'd2, 32'd1);
        run(32'h00221820);
        chk("add_result", last.result, 32'd2);
        chk_reg(5'd3, 32'd2);

        // signed overflow traps, unsigned does not
        preload(5'd1, 32'h7FFFFFFF);
        preload(5'd2, 32'h7FFFFFFF);
        preload(5'd3, 32'h12345678);
        run(32'h00221820);
        chk("add_ovf_exc", {31'd0, last.exc}, 32'd1);
        chk_reg(5'd3, 32'h12345678);
        run(32'h00221821);
        chk("addu_exc", {31'd0, last.exc}, 32'd0);
        chk_reg(5'd3, 32'hFFFFFFFE);

        // branches
        preload(5'd1, 32'd1);
        preload(5'd2, 32'd1);
        run(32'h10220000);
        chk("beq_taken", {31'd0, last.taken}, 32'd1);
        run(32'h14220000);
        chk("bne_not_taken", {31'd0, last.taken}, 32'd0);
        preload(5'd2, 32'd0);
        run(32'h14220000);
        chk("bne_taken", {31'd0, last.taken}, 32'd1);
        chk_reg(5'd3, 32'hFFFFFFFE);

        // write to $0 discarded
        run(32'h20200005);
        chk("addi_r0_result", last.result, 32'd6);
        chk_reg(5'd0, 32'd0);

        // preload coinciding with accept is forwarded: add $6,$5,$0
        @(negedge clk);
        wait_idle();
        init_we = 1'b1; init_addr = 5'd5; init_data = 32'd9;
        m[5] = 32'd9;
        send(32'h00A03020);
        init_we = 1'b0;
        wait_done();
        release_done();
        chk_reg(5'd6, 32'd9);

        // backpressure on retire
        preload(5'd7, 32'h00000077);
        send(32'h00221820);
        wait_done();
        held_result = bus.done_result;
        bus.instr_valid = 1'b1;
        bus.instr = 32'h00223821;
        init_we = 1'b1; init_addr = 5'd7; init_data = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_done_valid", {31'd0, bus.done_valid}, 32'd1);
            chk("hold_instr_ready", {31'd0, bus.instr_ready}, 32'd0);
            chk("hold_done_result", bus.done_result, held_result);
            chk("hold_alu_instruction", alu_instruction, 32'h00221820);
        end
        init_we = 1'b0;
        bus.done_ready = 1'b1;
        @(negedge clk);
        bus.done_ready = 1'b0;
        chk("hold_back_idle", {31'd0, bus.instr_ready}, 32'd1);
        chk_reg(5'd7, 32'h00000077);
        sb.push_back(predict(32'h00223821));
        @(negedge clk);
        bus.instr_valid = 1'b0;
        chk("second_accept", alu_instruction, 32'h00223821);
        wait_done();
        release_done();
        chk_reg(5'd7, m[7]);

        // reset while an add is in EXEC
        preload(5'd1, 32'd1);
        preload(5'd2, 32'd1);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr = 32'h00221820;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_alu_instruction", alu_instruction, 32'd0);
        chk("rst_alu_regA", alu_regA, 32'd0);
        chk("rst_alu_regB", alu_regB, 32'd0);
        chk("rst_done_valid", {31'd0, bus.done_valid}, 32'd0);
        chk("rst_instr_ready", {31'd0, bus.instr_ready}, 32'd1);
        for (int i = 0; i < 32; i++) m[i] = '0;
        chk_reg(5'd3, 32'd0);
        chk_reg(5'd1, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reg(5'd3, 32'd0);

        // unsupported opcode
        preload(5'd1, 32'd4);
        preload(5'd3, 32'h00000055);
        run(32'hFC221800);
        chk("illegal_flag", {31'd0, last.illegal}, 32'd1);
        chk_reg(5'd3, 32'h00000055);

        // randomised mix of supported operations
        for (int r = 1; r < 8; r++) preload(r[4:0], $urandom);
        for (int k = 0; k < 24; k++) begin
            int sel;
            sel = $urandom_range(0, 22);
            ins = '0;
            ins[25:21] = 5'($urandom_range(1, 7));
            ins[20:16] = 5'($urandom_range(0, 7));
            if (sel < 16) begin
                ins[15:11] = 5'($urandom_range(0, 7));
                ins[10:6]  = 5'($urandom_range(0, 31));
                ins[5:0]   = rfun[sel];
            end else begin
                ins[31:26] = iops[sel - 16];
                ins[15:0]  = 16'($urandom);
            end
            run(ins);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
Initiator side of the ALU interface. Accepts one MIPS instruction at a time over a valid/ready handshake and reads rs/rt from an internal 32x32 register file. Drives the combinational alu's instruction/regA/regB inputs, captures result/flags, and writes the result back to the register file. Reports completion over a second valid/ready handshake. Sits between the fetch stage and the alu in the multi-cycle datapath.

Parameters:
NREGS, 32, register file depth; $0 is hardwired to zero.
XLEN, 32, data and instruction width.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction offered
instr  in  32  MIPS instruction word
instr_ready  out  1  unit can accept an instruction (IDLE only)
alu_instruction  out  32  to alu.instruction
alu_regA  out  32  to alu.regA, R[rs]
alu_regB  out  32  to alu.regB, R[rt]
alu_result  in  32  from alu.result
alu_flags  in  3  from alu.flags: [2]=zero, [1]=negative, [0]=overflow
done_valid  out  1  retire record valid
done_ready  in  1  retire record consumed
done_result  out  32  captured alu_result
done_flags  out  3  captured alu_flags
done_branch_taken  out  1  beq: zero; bne: ~zero; else 0
done_exc  out  1  overflow on add/addi/sub; write suppressed
done_illegal  out  1  unsupported opcode/funct; no write
init_we, init_addr[4:0], init_data[31:0]  in  preload write port, honoured in IDLE only
dbg_addr  in  5  debug read address
dbg_data  out  32  R[dbg_addr], combinational

Behaviour:
- Reset (async, any state): FSM to IDLE; all registered outputs 0; all registers 0; any in-flight instruction dropped with no writeback.
- States: IDLE, EXEC, RETIRE.
- IDLE: instr_ready=1. On the edge where instr_valid&&instr_ready:
  - alu_instruction<=instr, alu_regA<=R[instr[25:21]], alu_regB<=R[instr[20:16]].
  - Decode destination/class into internal registers.
  - Go to EXEC.
- init_we in IDLE writes R[init_addr]. If it coincides with an accept, the init write completes first, and the operand read sees the new value (bypass). init_we is ignored outside IDLE.
- EXEC (1 cycle; the alu is combinational): at the edge, sample alu_result/alu_flags into done_*; perform writeback; go to RETIRE.
- RETIRE: done_valid=1, outputs stable. The edge with done_ready=1 goes to IDLE and clears done_valid. instr_ready=0 until back in IDLE.
- Accept-to-done_valid latency: 2 cycles. Minimum throughput: 1 instruction per 3 cycles.
- Writeback destination:
  - rd (instr[15:11]) for R-type funct add, addu, sub, subu, and, or, nor, xor, slt, sltu, sll, sllv, srl, srlv, sra, srav.
  - rt for addi, addiu, andi, ori, xori, slti, sltiu.
  - No write for beq, bne, lw, sw; done_result carries the address or difference.
- Writes to $0 are discarded; R0 always reads 0.
- Overflow (alu_flags[0]=1) on add/addi/sub: no write, done_exc=1. addu/addiu/subu ignore the overflow flag.
- Unrecognised opcode/funct: the ALU is still driven, but there is no write; done_illegal=1, done_exc=0.
- alu_* outputs hold their value until the next accept.

Test Plan:
- Preload R1=1, R2=1. Issue 0x00221820 (add $3,$1,$2):
  - alu_regA=1, alu_regB=1 in the cycle after accept.
  - done_valid 2 cycles after accept, done_result=2, done_flags[0]=0, dbg R3=2.
- Preload R1=R2=0x7FFFFFFF, R3=0x12345678. Issue add $3,$1,$2 -> done_exc=1, done_flags[0]=1, R3 stays 0x12345678. The same operands with addu -> R3=0xFFFFFFFE, done_exc=0.
- R1=R2=1:
  - beq $1,$2 (0x10220000) -> done_branch_taken=1, no register changes.
  - bne (0x14220000) -> done_branch_taken=0.
  - R2=0, bne -> 1.
- addi $0,$1,5 (0x20200005) with R1=1 -> done_result=6, R0 reads 0.
- Hold done_ready=0 for 5 cycles with instr_valid=1:
  - done_valid and done_* stay stable, instr_ready=0, no second accept.
  - Raise done_ready -> IDLE next cycle, then accept.
- Assert rst during EXEC of add $3 -> all outputs 0 at once, R3=0, FSM in IDLE. Opcode 0x3F -> done_illegal=1, no write.
